// File: rtl/dino_frame_writer.sv
// -----------------------------------------------------------------------------
// dino_frame_writer
//
// Once per video frame this block advances the dino-runner game by one step
// (dino jump physics, cactus scroll, score, collision) and then pushes the
// whole 13-entry sprite/score register file over a simple zero-wait-state
// bus, addresses 0..12 in ascending order, one write per cycle.
//
// Optional feature macro: DINO_DUCK_EN
//   defined   : the duck input shows the duck sprite while the dino is on
//               the ground.
//   undefined : duck is ignored and the duck sprite (addresses 4/5) always
//               stays parked.
//
// Ports
//   clk         sole clock
//   reset       synchronous, active-high reset
//   frame_tick  one-cycle pulse per video frame
//   jump        level, jump request
//   duck        level, duck request
//   start       level, restart after game over
//   chipselect  bus select (always equal to write)
//   write       bus write strobe
//   address     register index 0..12
//   writedata   register value, bits 31:8 zero
//   busy        update/write sequence in progress
//   game_over   collision latched
//   overrun     sticky, a frame_tick arrived while busy
//
// Register map: 0/1 dino x/y, 2/3 jump x/y, 4/5 duck x/y, 6/7 cactus x/y,
// 8/9 godzilla (always parked), 10 score, 11/12 score position.
// -----------------------------------------------------------------------------
module dino_frame_writer #(
  parameter logic [7:0] DINO_X   = 8'd100,
  parameter logic [7:0] GROUND_Y = 8'd100,
  parameter int         JUMP_V   = 8,
  parameter int         SPEED    = 2,
  parameter logic [7:0] PARK     = 8'd0,
  parameter logic [7:0] SCORE_X  = 8'd8,
  parameter logic [7:0] SCORE_Y  = 8'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        jump,
  input  logic        duck,
  input  logic        start,
  output logic        chipselect,
  output logic        write,
  output logic [8:0]  address,
  output logic [31:0] writedata,
  output logic        busy,
  output logic        game_over,
  output logic        overrun
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_WRITE  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'd12;

  state_t             r_state;
  logic               r_write;
  logic               r_chipselect;
  logic [8:0]         r_address;
  logic [31:0]        r_writedata;
  logic               r_busy;
  logic               r_game_over;
  logic               r_overrun;
  logic [3:0]         r_idx;
  logic [7:0]         r_y;
  logic signed [5:0]  r_vy;
  logic [7:0]         r_cac_x;
  logic [3:0]         r_score;
  logic               r_duck_lat;

  logic               w_duck_in;

`ifdef DINO_DUCK_EN
  assign w_duck_in = duck;
`else
  logic w_unused_duck;
  assign w_unused_duck = duck;
  assign w_duck_in     = 1'b0;
`endif

  // Value written to register idx for a given game state. The dino is
  // airborne whenever it has vertical speed or is above the ground; the jump
  // sprite wins over the duck sprite.
  function automatic logic [7:0] reg_val(
    input logic [3:0]        idx,
    input logic [7:0]        y,
    input logic signed [5:0] vy,
    input logic [7:0]        cac,
    input logic [3:0]        score,
    input logic              dk
  );
    logic air;
    logic ducking;
    air     = (vy != 6'sd0) || (y < GROUND_Y);
    ducking = !air && dk;
    case (idx)
      4'd0:    reg_val = (air || ducking) ? PARK : DINO_X;
      4'd1:    reg_val = (air || ducking) ? PARK : GROUND_Y;
      4'd2:    reg_val = air ? DINO_X : PARK;
      4'd3:    reg_val = air ? y : PARK;
      4'd4:    reg_val = ducking ? DINO_X : PARK;
      4'd5:    reg_val = ducking ? GROUND_Y : PARK;
      4'd6:    reg_val = cac;
      4'd7:    reg_val = GROUND_Y;
      4'd10:   reg_val = {4'd0, score};
      4'd11:   reg_val = SCORE_X;
      4'd12:   reg_val = SCORE_Y;
      default: reg_val = PARK;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // One frame of game movement, computed from the current state.
  // ---------------------------------------------------------------------------
  logic signed [5:0]  w_vy_a;     // speed after a possible jump launch
  logic signed [9:0]  w_ysum;     // wide so the landing test cannot wrap
  logic [7:0]         w_y_n;
  logic signed [5:0]  w_vy_n;
  logic [7:0]         w_cac_n;
  logic [3:0]         w_score_n;
  logic               w_hit;

  always_comb begin
    w_vy_a    = r_vy;
    w_y_n     = r_y;
    w_vy_n    = r_vy;
    w_ysum    = 10'sd0;
    w_cac_n   = r_cac_x - 8'(SPEED);
    w_score_n = r_score;

    if ((r_y == GROUND_Y) && (r_vy == 6'sd0) && jump) begin
      w_vy_a = 6'(-JUMP_V);
    end
    w_vy_n = w_vy_a;

    // The launch frame already moves, so the first airborne y is GROUND_Y-JUMP_V.
    if ((w_vy_a != 6'sd0) || (r_y < GROUND_Y)) begin
      w_ysum = $signed({2'b00, r_y}) + $signed({{4{w_vy_a[5]}}, w_vy_a});
      if (w_ysum >= $signed({2'b00, GROUND_Y})) begin
        w_y_n  = GROUND_Y;
        w_vy_n = 6'sd0;
      end else begin
        w_y_n  = w_ysum[7:0];
        w_vy_n = w_vy_a + 6'sd1;
      end
    end

    if (r_cac_x < 8'(SPEED)) begin
      w_cac_n   = 8'd255;
      w_score_n = (r_score == 4'd9) ? 4'd0 : r_score + 4'd1;
    end

    w_hit = (({1'b0, w_cac_n} + 9'd24) > {1'b0, DINO_X}) &&
            ({1'b0, w_cac_n} < ({1'b0, DINO_X} + 9'd24)) &&
            (({1'b0, w_y_n} + 9'd24) > {1'b0, GROUND_Y});
  end

  // State seen by the writes of this frame: frozen once the game is over.
  logic [7:0]         w_y_u;
  logic signed [5:0]  w_vy_u;
  logic [7:0]         w_cac_u;
  logic [3:0]         w_score_u;
  logic               w_duck_u;

  assign w_y_u     = r_game_over ? r_y        : w_y_n;
  assign w_vy_u    = r_game_over ? r_vy       : w_vy_n;
  assign w_cac_u   = r_game_over ? r_cac_x    : w_cac_n;
  assign w_score_u = r_game_over ? r_score    : w_score_n;
  assign w_duck_u  = r_game_over ? r_duck_lat : w_duck_in;

  // ---------------------------------------------------------------------------
  // Control FSM with registered bus outputs. Address 0 is launched on the
  // UPDATE->WRITE edge from the freshly computed state; later addresses read
  // the registered state, which by then holds the same values.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_write      <= 1'b0;
      r_chipselect <= 1'b0;
      r_address    <= 9'd0;
      r_writedata  <= 32'd0;
      r_busy       <= 1'b0;
      r_game_over  <= 1'b0;
      r_overrun    <= 1'b0;
      r_idx        <= 4'd0;
      r_y          <= GROUND_Y;
      r_vy         <= 6'sd0;
      r_cac_x      <= 8'd255;
      r_score      <= 4'd0;
      r_duck_lat   <= 1'b0;
    end else begin
      if (frame_tick && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (start && r_game_over) begin
            r_y         <= GROUND_Y;
            r_vy        <= 6'sd0;
            r_cac_x     <= 8'd255;
            r_score     <= 4'd0;
            r_game_over <= 1'b0;
            r_duck_lat  <= 1'b0;
          end
          if (frame_tick) begin
            r_state <= S_UPDATE;
            r_busy  <= 1'b1;
          end
        end

        S_UPDATE: begin
          if (!r_game_over) begin
            r_y         <= w_y_n;
            r_vy        <= w_vy_n;
            r_cac_x     <= w_cac_n;
            r_score     <= w_score_n;
            r_duck_lat  <= w_duck_in;
            r_game_over <= w_hit;
          end
          r_state      <= S_WRITE;
          r_write      <= 1'b1;
          r_chipselect <= 1'b1;
          r_address    <= 9'd0;
          r_writedata  <= {24'd0, reg_val(4'd0, w_y_u, w_vy_u, w_cac_u,
                                          w_score_u, w_duck_u)};
          r_idx        <= 4'd1;
        end

        S_WRITE: begin
          if (r_idx > LAST_IDX) begin
            r_state      <= S_IDLE;
            r_write      <= 1'b0;
            r_chipselect <= 1'b0;
            r_busy       <= 1'b0;
          end else begin
            r_address   <= {5'd0, r_idx};
            r_writedata <= {24'd0, reg_val(r_idx, r_y, r_vy, r_cac_x,
                                           r_score, r_duck_lat)};
            r_idx       <= r_idx + 4'd1;
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_write      <= 1'b0;
          r_chipselect <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign chipselect = r_chipselect;
  assign write      = r_write;
  assign address    = r_address;
  assign writedata  = r_writedata;
  assign busy       = r_busy;
  assign game_over  = r_game_over;
  assign overrun    = r_overrun;

endmodule
